// File: rtl/ram_port_arbiter_if.sv
// Bundle of both requester ports and the RAM port-A signals shared by ram_port_arbiter.
// slave = arbiter side; master = requesters plus RAM model side.
interface ram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 30,
  parameter int unsigned DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [3:0]        m0_byteen;
  logic              m0_gnt;
  logic              m0_rvalid;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [3:0]        m1_byteen;
  logic              m1_lock;
  logic              m1_gnt;
  logic              m1_rvalid;

  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data;
  logic [3:0]        ram_byteena;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_byteen,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_byteen, m1_lock,
    output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata,
    output ram_address, ram_data, ram_byteena, ram_wren,
    input  ram_q
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_byteen,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_byteen, m1_lock,
    input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, rdata,
    input  ram_address, ram_data, ram_byteena, ram_wren,
    output ram_q
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port between the CPU (m0, priority) and a DMA engine (m1, starvation-protected,
// lockable bursts); tags reads so rvalid returns to the issuer after RD_LAT clocks.
module ram_port_arbiter #(
  parameter int unsigned ADDR_W       = 30,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RD_LAT       = 1,
  parameter int unsigned MAX_BURST    = 8,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  ram_port_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] MAX_B      = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DMA_LOCK = 2'd1,
    YIELD    = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0]  burst_inc_c;
  logic [RD_LAT-1:0] rv0_q, rv0_d;
  logic [RD_LAT-1:0] rv1_q, rv1_d;
  logic              gnt0_c, gnt1_c;

  // Grant selection from registered state and live requests
  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (state_q == DMA_LOCK && bus.m1_req) begin
      gnt1_c = 1'b1;
    end else if (state_q == YIELD && bus.m0_req) begin
      gnt0_c = 1'b1;
    end else if (bus.m1_req && starve_cnt_q >= STARVE_MAX) begin
      gnt1_c = 1'b1;
    end else if (bus.m0_req) begin
      gnt0_c = 1'b1;
    end else if (bus.m1_req) begin
      gnt1_c = 1'b1;
    end
  end

  // RAM port mux; idle cycles park on m0 fields with writes disabled
  always_comb begin
    bus.ram_address = bus.m0_addr;
    bus.ram_data    = bus.m0_wdata;
    bus.ram_byteena = 4'b1111;
    bus.ram_wren    = 1'b0;
    if (gnt1_c) begin
      bus.ram_address = bus.m1_addr;
      bus.ram_data    = bus.m1_wdata;
      if (bus.m1_we) begin
        bus.ram_wren    = 1'b1;
        bus.ram_byteena = bus.m1_byteen;
      end
    end else if (gnt0_c) begin
      if (bus.m0_we) begin
        bus.ram_wren    = 1'b1;
        bus.ram_byteena = bus.m0_byteen;
      end
    end
  end

  assign bus.m0_gnt    = gnt0_c;
  assign bus.m1_gnt    = gnt1_c;
  assign bus.m0_rvalid = rv0_q[RD_LAT-1];
  assign bus.m1_rvalid = rv1_q[RD_LAT-1];
  assign bus.rdata     = bus.ram_q;

  assign burst_inc_c = burst_cnt_q + CNT_W'(1);

  // Burst-lock FSM: next state and burst count
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (gnt1_c && bus.m1_lock) begin
          burst_cnt_d = CNT_W'(1);
          state_d     = (CNT_W'(1) >= MAX_B) ? YIELD : DMA_LOCK;
        end
      end
      DMA_LOCK: begin
        if (!bus.m1_lock || !bus.m1_req) begin
          state_d     = IDLE;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = burst_inc_c;
          if (burst_inc_c >= MAX_B) state_d = YIELD;
        end
      end
      YIELD: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  // Starvation counter saturates so the DMA priority slot stays armed until taken
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.m1_req || gnt1_c) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < STARVE_MAX) begin
      starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end
  end

  // Per-owner read tag shift pipes, one bit per stage
  always_comb begin
    rv0_d    = rv0_q;
    rv1_d    = rv1_q;
    rv0_d[0] = gnt0_c & ~bus.m0_we;
    rv1_d[0] = gnt1_c & ~bus.m1_we;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      rv0_d[i] = rv0_q[i-1];
      rv1_d[i] = rv1_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
      burst_cnt_q  <= '0;
      rv0_q        <= '0;
      rv1_q        <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
      rv0_q        <= rv0_d;
      rv1_q        <= rv1_d;
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: instance a uses RD_LAT=1, instance b RD_LAT=2 for reset-in-flight.
module tb_ram_port_arbiter;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  ram_port_arbiter_if #(.ADDR_W(30), .DATA_W(32)) ifa ();
  ram_port_arbiter_if #(.ADDR_W(30), .DATA_W(32)) ifb ();

  ram_port_arbiter #(.ADDR_W(30), .DATA_W(32), .RD_LAT(1), .MAX_BURST(8), .STARVE_LIMIT(16))
    u_dut_a (.clk(clk), .reset_n(reset_n), .bus(ifa));
  ram_port_arbiter #(.ADDR_W(30), .DATA_W(32), .RD_LAT(2), .MAX_BURST(8), .STARVE_LIMIT(16))
    u_dut_b (.clk(clk), .reset_n(reset_n), .bus(ifb));

  function automatic logic [31:0] mem_f(input logic [29:0] a);
    return {2'b00, a} ^ 32'hC0DE_0000;
  endfunction

  // RAM models: registered address, q a fixed function of the address
  logic [29:0] a_addr_d1, b_addr_d1, b_addr_d2;
  always @(posedge clk) begin
    a_addr_d1 <= ifa.ram_address;
    b_addr_d1 <= ifb.ram_address;
    b_addr_d2 <= b_addr_d1;
  end
  assign ifa.ram_q = mem_f(a_addr_d1);
  assign ifb.ram_q = mem_f(b_addr_d2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got no finish want finish");
    $fatal(1);
  end

  task automatic clear_a();
    ifa.m0_req = 0; ifa.m0_we = 0; ifa.m0_addr = '0; ifa.m0_wdata = '0; ifa.m0_byteen = '0;
    ifa.m1_req = 0; ifa.m1_we = 0; ifa.m1_addr = '0; ifa.m1_wdata = '0; ifa.m1_byteen = '0;
    ifa.m1_lock = 0;
  endtask

  task automatic clear_b();
    ifb.m0_req = 0; ifb.m0_we = 0; ifb.m0_addr = '0; ifb.m0_wdata = '0; ifb.m0_byteen = '0;
    ifb.m1_req = 0; ifb.m1_we = 0; ifb.m1_addr = '0; ifb.m1_wdata = '0; ifb.m1_byteen = '0;
    ifb.m1_lock = 0;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    obs = {ifa.m0_gnt, ifa.m1_gnt, ifa.m0_rvalid, ifa.m1_rvalid, ifa.ram_wren};
    n_tests++;
    if (obs !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_held: got %b want %b", obs, 5'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      obs = {ifa.m0_gnt, ifa.m1_gnt, ifa.m0_rvalid, ifa.m1_rvalid, ifa.ram_wren};
      n_tests++;
      if (obs !== 5'b0 || ifa.ram_byteena !== 4'hF) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d: got %b/%h want %b/%h", c, obs, ifa.ram_byteena, 5'b0, 4'hF);
      end
    end
  endtask

  task automatic test_m0_read();
    logic [2:0] obs;
    @(negedge clk);
    ifa.m0_req = 1; ifa.m0_we = 0; ifa.m0_addr = 30'h100; ifa.m0_byteen = 4'b0001;
    #1;
    obs = {ifa.m0_gnt, ifa.m1_gnt, ifa.ram_wren};
    n_tests++;
    if (obs !== 3'b100 || ifa.ram_address !== 30'h100 || ifa.ram_byteena !== 4'hF) begin
      n_fail++;
      $display("FAIL m0_read_gnt: got %b addr %h be %h want 100 addr 100 be f",
               obs, ifa.ram_address, ifa.ram_byteena);
    end
    @(negedge clk);
    clear_a();
    #1;
    n_tests++;
    if ({ifa.m0_rvalid, ifa.m1_rvalid} !== 2'b10 || ifa.rdata !== mem_f(30'h100)) begin
      n_fail++;
      $display("FAIL m0_read_data: got rv %b data %h want rv 10 data %h",
               {ifa.m0_rvalid, ifa.m1_rvalid}, ifa.rdata, mem_f(30'h100));
    end
    @(negedge clk);
    #1;
    n_tests++;
    if ({ifa.m0_rvalid, ifa.m1_rvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL m0_read_pulse: got %b want 00", {ifa.m0_rvalid, ifa.m1_rvalid});
    end
  endtask

  task automatic test_m0_write();
    @(negedge clk);
    ifa.m0_req = 1; ifa.m0_we = 1; ifa.m0_addr = 30'h123; ifa.m0_wdata = 32'hDEADBEEF;
    ifa.m0_byteen = 4'b0110;
    #1;
    n_tests++;
    if ({ifa.m0_gnt, ifa.m1_gnt, ifa.ram_wren} !== 3'b101 || ifa.ram_byteena !== 4'b0110 ||
        ifa.ram_data !== 32'hDEADBEEF || ifa.ram_address !== 30'h123) begin
      n_fail++;
      $display("FAIL m0_write: got %b be %b data %h addr %h want 101 be 0110 data deadbeef addr 123",
               {ifa.m0_gnt, ifa.m1_gnt, ifa.ram_wren}, ifa.ram_byteena, ifa.ram_data, ifa.ram_address);
    end
    @(negedge clk);
    clear_a();
    #1;
    n_tests++;
    if ({ifa.m0_rvalid, ifa.m1_rvalid, ifa.ram_wren} !== 3'b000) begin
      n_fail++;
      $display("FAIL m0_write_no_rvalid: got %b want 000", {ifa.m0_rvalid, ifa.m1_rvalid, ifa.ram_wren});
    end
  endtask

  task automatic test_starve();
    logic [1:0] exp;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) begin
        ifa.m0_req = 1; ifa.m0_we = 0; ifa.m0_addr = 30'h10;
        ifa.m1_req = 1; ifa.m1_we = 0; ifa.m1_addr = 30'h20;
      end
      #1;
      exp = (c == 16) ? 2'b01 : 2'b10;
      n_tests++;
      if ({ifa.m0_gnt, ifa.m1_gnt} !== exp ||
          ifa.ram_address !== ((c == 16) ? 30'h20 : 30'h10)) begin
        n_fail++;
        $display("FAIL starve c=%0d: got gnt %b addr %h want gnt %b", c,
                 {ifa.m0_gnt, ifa.m1_gnt}, ifa.ram_address, exp);
      end
    end
    @(negedge clk);
    clear_a();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_burst();
    logic [1:0] exp;
    for (int c = 0; c < 42; c++) begin
      @(negedge clk);
      if (c == 0) begin
        ifa.m0_req = 1; ifa.m0_we = 0; ifa.m0_addr = 30'h11;
        ifa.m1_req = 1; ifa.m1_we = 1; ifa.m1_addr = 30'h30; ifa.m1_wdata = 32'h1234_5678;
        ifa.m1_byteen = 4'b1111; ifa.m1_lock = 1;
      end
      #1;
      exp = ((c >= 16 && c <= 23) || c >= 40) ? 2'b01 : 2'b10;
      n_tests++;
      if ({ifa.m0_gnt, ifa.m1_gnt} !== exp) begin
        n_fail++;
        $display("FAIL burst c=%0d: got gnt %b want %b", c, {ifa.m0_gnt, ifa.m1_gnt}, exp);
      end
    end
    @(negedge clk);
    clear_a();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_alternating();
    logic        prev_owner;
    logic [29:0] prev_addr;
    logic [29:0] a;
    logic [1:0]  exp;
    prev_owner = 1'b0;
    prev_addr  = '0;
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      clear_a();
      a = 30'(c) + (((c % 2) == 0) ? 30'h200 : 30'h300);
      if (c < 8) begin
        if ((c % 2) == 0) begin
          ifa.m0_req = 1; ifa.m0_addr = a;
        end else begin
          ifa.m1_req = 1; ifa.m1_addr = a;
        end
      end
      #1;
      if (c < 8) begin
        exp = ((c % 2) == 0) ? 2'b10 : 2'b01;
        n_tests++;
        if ({ifa.m0_gnt, ifa.m1_gnt} !== exp) begin
          n_fail++;
          $display("FAIL alt_gnt c=%0d: got %b want %b", c, {ifa.m0_gnt, ifa.m1_gnt}, exp);
        end
      end
      if (c > 0) begin
        exp = prev_owner ? 2'b01 : 2'b10;
        n_tests++;
        if ({ifa.m0_rvalid, ifa.m1_rvalid} !== exp || ifa.rdata !== mem_f(prev_addr)) begin
          n_fail++;
          $display("FAIL alt_rvalid c=%0d: got rv %b data %h want rv %b data %h", c,
                   {ifa.m0_rvalid, ifa.m1_rvalid}, ifa.rdata, exp, mem_f(prev_addr));
        end
      end
      prev_owner = ((c % 2) == 1);
      prev_addr  = a;
    end
    @(negedge clk);
    #1;
    n_tests++;
    if ({ifa.m0_rvalid, ifa.m1_rvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL alt_tail: got %b want 00", {ifa.m0_rvalid, ifa.m1_rvalid});
    end
  endtask

  task automatic test_reset_flight();
    @(negedge clk);
    ifb.m0_req = 1; ifb.m0_we = 0; ifb.m0_addr = 30'h40;
    #1;
    n_tests++;
    if ({ifb.m0_gnt, ifb.m1_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL flight_gnt0: got %b want 10", {ifb.m0_gnt, ifb.m1_gnt});
    end
    @(negedge clk);
    clear_b();
    ifb.m1_req = 1; ifb.m1_we = 0; ifb.m1_addr = 30'h44; ifb.m1_lock = 1;
    #1;
    n_tests++;
    if ({ifb.m0_gnt, ifb.m1_gnt} !== 2'b01) begin
      n_fail++;
      $display("FAIL flight_gnt1: got %b want 01", {ifb.m0_gnt, ifb.m1_gnt});
    end
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    clear_b();
    #1;
    n_tests++;
    if ({ifb.m0_rvalid, ifb.m1_rvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL flight_in_reset: got %b want 00", {ifb.m0_rvalid, ifb.m1_rvalid});
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      n_tests++;
      if ({ifb.m0_rvalid, ifb.m1_rvalid} !== 2'b00) begin
        n_fail++;
        $display("FAIL flight_after c=%0d: got %b want 00", c, {ifb.m0_rvalid, ifb.m1_rvalid});
      end
    end
    // Had the lock state survived reset, m1 would win over m0 here
    @(negedge clk);
    ifb.m0_req = 1; ifb.m0_addr = 30'h50;
    ifb.m1_req = 1; ifb.m1_addr = 30'h54; ifb.m1_lock = 1;
    #1;
    n_tests++;
    if ({ifb.m0_gnt, ifb.m1_gnt} !== 2'b10) begin
      n_fail++;
      $display("FAIL flight_fsm_idle: got %b want 10", {ifb.m0_gnt, ifb.m1_gnt});
    end
    @(negedge clk);
    clear_b();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    clear_a();
    clear_b();
    test_reset();
    test_m0_read();
    test_m0_write();
    test_starve();
    test_burst();
    test_alternating();
    test_reset_flight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
